// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issue/retire control between execute and the iterative divider.
// Divide-by-zero, signed overflow and repeats of the last divider op retire locally.
module div_issue_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [XLEN-1:0]     in_rs1,
  input  logic [XLEN-1:0]     in_rs2,
  input  logic [REG_BITS-1:0] in_rd,
  input  logic                flush,
  output logic                stall,
  output logic                div_start,
  output logic [2:0]          div_op,
  output logic [XLEN-1:0]     div_dividend,
  output logic [XLEN-1:0]     div_divisor,
  input  logic                div_busy,
  input  logic                div_finished,
  input  logic [XLEN-1:0]     div_result,
  output logic                wb_valid,
  output logic [REG_BITS-1:0] wb_rd,
  output logic [XLEN-1:0]     wb_data
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_DRAIN  = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;

  logic [2:0]          op_q;
  logic [XLEN-1:0]     rs1_q, rs2_q, res_q;
  logic [REG_BITS-1:0] rd_q;
  logic                div_start_q;

  logic                cache_vld_q;
  logic [2:0]          cache_op_q;
  logic [XLEN-1:0]     cache_rs1_q, cache_rs2_q, cache_res_q;

  logic [REG_BITS-1:0] wb_rd_q;
  logic [XLEN-1:0]     wb_data_q;

  logic            accept;
  logic            fast_hit;
  logic [XLEN-1:0] fast_res;
  logic            load_in, load_res, cache_wr;

  // Handshake: reset and a still-busy divider both block acceptance.
  assign in_ready = rst_n && (state_q == S_IDLE) && !div_busy;
  assign accept   = in_valid && in_ready && in_op[2];
  assign stall    = (in_valid && !in_ready) || (state_q != S_IDLE);

  // Operands to the divider come straight from the latched op so they stay stable.
  assign div_start    = div_start_q;
  assign div_op       = op_q;
  assign div_dividend = rs1_q;
  assign div_divisor  = rs2_q;

  // Writeback strobe can be killed by a same-cycle flush; data holds otherwise.
  assign wb_valid = (state_q == S_DONE) && !flush;
  assign wb_rd    = wb_valid ? rd_q  : wb_rd_q;
  assign wb_data  = wb_valid ? res_q : wb_data_q;

  // Locally resolvable results: divide-by-zero, signed overflow, last-op cache.
  always_comb begin
    fast_hit = 1'b1;
    fast_res = '0;
    if (in_rs2 == '0) begin
      fast_res = in_op[1] ? in_rs1 : ALL_ONES;
    end else if (!in_op[0] && (in_rs1 == INT_MIN) && (in_rs2 == ALL_ONES)) begin
      fast_res = in_op[1] ? '0 : INT_MIN;
    end else if (cache_vld_q && (in_op == cache_op_q) &&
                 (in_rs1 == cache_rs1_q) && (in_rs2 == cache_rs2_q)) begin
      fast_res = cache_res_q;
    end else begin
      fast_hit = 1'b0;
    end
  end

  // Next-state and datapath load enables.
  always_comb begin
    state_d  = state_q;
    load_in  = 1'b0;
    load_res = 1'b0;
    cache_wr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          load_in = 1'b1;
          state_d = fast_hit ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (flush) begin
          state_d = div_busy ? S_DRAIN : S_IDLE;
        end else if (div_busy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = div_finished ? S_IDLE : S_DRAIN;
        end else if (div_finished) begin
          load_res = 1'b1;
          cache_wr = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (div_finished) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and launch request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_start_q <= (state_d == S_LAUNCH);
    end
  end

  // Latched op, result, last-op cache and writeback hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      res_q       <= '0;
      cache_vld_q <= 1'b0;
      cache_op_q  <= '0;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_res_q <= '0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
    end else begin
      if (load_in) begin
        op_q  <= in_op;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        rd_q  <= in_rd;
        res_q <= fast_res;
      end
      if (load_res) begin
        res_q <= div_result;
      end
      if (cache_wr) begin
        cache_vld_q <= 1'b1;
        cache_op_q  <= op_q;
        cache_rs1_q <= rs1_q;
        cache_rs2_q <= rs2_q;
        cache_res_q <= div_result;
      end
      if (wb_valid) begin
        wb_rd_q   <= rd_q;
        wb_data_q <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a simple multi-cycle divider model.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        stall;
  logic        div_start;
  logic [2:0]  div_op;
  logic [31:0] div_dividend, div_divisor;
  logic        div_busy = 1'b0;
  logic        div_finished;
  logic [31:0] div_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_errors = 0;
  int lat      = 3;
  int launches = 0;
  int cnt      = 0;

  div_issue_ctrl #(.XLEN(32), .REG_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .flush(flush), .stall(stall),
    .div_start(div_start), .div_op(div_op),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_finished(div_finished), .div_result(div_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Divider model: no reset, busy for lat cycles, result from live inputs.
  function automatic logic [31:0] div_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    if (b == 32'd0) return 32'd0;
    case (op)
      3'b100:  return 32'($signed(a) / $signed(b));
      3'b101:  return a / b;
      3'b110:  return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  assign div_finished = div_busy && (cnt == 0);
  assign div_result   = div_finished ? div_model(div_op, div_dividend, div_divisor) : 32'd0;

  always @(posedge clk) begin
    if (!div_busy && div_start) begin
      div_busy <= 1'b1;
      cnt      <= lat - 1;
      launches <= launches + 1;
    end else if (div_busy) begin
      if (cnt == 0) div_busy <= 1'b0;
      else          cnt      <= cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Present one op and hold it until the accepting clock edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
    check("in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Full op: latency, divider launch count, writeback value and one-cycle strobe.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input bit fast);
    int l0, cyc;
    bit seen;
    l0 = launches; seen = 1'b0; cyc = 0;
    issue(op, a, b, rd);
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (wb_valid) begin cyc = i; seen = 1'b1; break; end
    end
    if (!seen) begin
      check("wb_timeout", 32'd0, 32'd1);
    end else begin
      check("wb_data", wb_data, exp);
      check("wb_rd", 32'(wb_rd), 32'(rd));
      check("latency", 32'(cyc), fast ? 32'd1 : 32'(2 + lat));
      check("launches", 32'(launches - l0), fast ? 32'd0 : 32'd1);
      @(negedge clk);
      check("wb_pulse", 32'(wb_valid), 32'd0);
      check("wb_hold", wb_data, exp);
      check("ready_after", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_rs1 = '0; in_rs2 = '0;
    in_rd = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_start", 32'(div_start), 32'd0);
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_wbdata", wb_data, 32'd0);
    check("rst_divop", 32'(div_op), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Non-divide funct3 is ignored.
    in_valid = 1'b1; in_op = 3'b000; in_rs1 = 32'd9; in_rs2 = 32'd3;
    check("nondiv_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("nondiv_wbv", 32'(wb_valid), 32'd0);
    check("nondiv_idle", 32'(stall), 32'd0);

    do_op(3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0);
    do_op(3'b101, 32'd100, 32'd7, 5'd6, 32'd14, 1'b1);          // cache hit
    do_op(3'b101, 32'd100, 32'd8, 5'd7, 32'd12, 1'b0);
    do_op(3'b111, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0);           // op is part of key
    do_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 1'b0);
    do_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFF, 1'b0);
    do_op(3'b100, 32'd5, 32'd0, 5'd9, 32'hFFFFFFFF, 1'b1);
    do_op(3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 1'b1);
    do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 1'b1);
    do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, 1'b1);

    // Flush two cycles into WAIT: drain without writeback or cache update.
    lat = 6;
    issue(3'b101, 32'd1000, 32'd3, 5'd13);
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    begin
      bit fin = 1'b0;
      for (int i = 0; i < 30; i++) begin
        check("drain_stall", 32'(stall), 32'd1);
        check("drain_wbv", 32'(wb_valid), 32'd0);
        if (div_finished) begin fin = 1'b1; break; end
        @(negedge clk);
      end
      check("drain_fin", 32'(fin), 32'd1);
    end
    @(negedge clk);
    check("drain_ready", 32'(in_ready), 32'd1);
    check("drain_wbhold", wb_data, 32'd0);
    do_op(3'b101, 32'd1000, 32'd3, 5'd14, 32'd333, 1'b0);       // no stale cache entry

    // Reset mid-WAIT while the divider keeps running.
    issue(3'b101, 32'd2000, 32'd7, 5'd15);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    check("mid_rst_start", 32'(div_start), 32'd0);
    check("mid_rst_wbdata", wb_data, 32'd0);
    check("mid_rst_wbrd", 32'(wb_rd), 32'd0);
    check("mid_rst_dvd", div_dividend, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("busy_after_rst", 32'(div_busy), 32'd1);
    begin
      bit idle = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (!div_busy) begin idle = 1'b1; break; end
        check("rst_busy_ready", 32'(in_ready), 32'd0);
        check("rst_busy_wbv", 32'(wb_valid), 32'd0);
        @(negedge clk);
      end
      check("busy_fell", 32'(idle), 32'd1);
    end
    check("rst_ready_back", 32'(in_ready), 32'd1);
    check("rst_stale_wbv", 32'(wb_valid), 32'd0);
    lat = 3;
    do_op(3'b101, 32'd100, 32'd7, 5'd16, 32'd14, 1'b0);         // cache cleared by reset

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
